pixel_scan_sequencer: RTL and testbench

- Sequences one full readout frame of the speckle sensor chip: row enable, row settle time, column shift clock and per-pixel ADC sample strobe.
- A frame starts on a rising edge of a level `start` input, which the block edge-detects internally.
- Sits in chip_driver between the host control/register layer and the sensor pads; the sample strobe drives the ADC capture path through a valid/ready handshake.
- Frame can be aborted at any time.

---
 rtl/pixel_scan_sequencer_if.sv | 30 +++
 rtl/pixel_scan_sequencer.sv | 140 ++++++++++++++
 tb/tb_pixel_scan_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_scan_sequencer_if.sv
// Control, status and sensor-side signals of the pixel scan sequencer.
// The sequencer takes the master modport; the host/ADC/sensor side takes the slave modport.
interface pixel_scan_sequencer_if #(
  parameter int N_ROWS = 24,
  parameter int N_COLS = 24
);
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  logic          start;
  logic          abort;
  logic          sample_ready;
  logic          busy;
  logic          done;
  logic          row_en;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic          chip_clk;
  logic          sample;

  modport master (
    input  start, abort, sample_ready,
    output busy, done, row_en, row_idx, col_idx, chip_clk, sample
  );

  modport slave (
    output start, abort, sample_ready,
    input  busy, done, row_en, row_idx, col_idx, chip_clk, sample
  );
endinterface

// File: rtl/pixel_scan_sequencer.sv
// Sequences one sensor readout frame: row settle, column shift clock and a
// per-pixel ADC sample strobe with valid/ready backpressure.
module pixel_scan_sequencer #(
  parameter int N_ROWS  = 24,
  parameter int N_COLS  = 24,
  parameter int CLK_DIV = 4,
  parameter int SETTLE  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pixel_scan_sequencer_if.master bus
);

  localparam int RW      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW      = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int CNT_MAX = (SETTLE > CLK_DIV) ? SETTLE : CLK_DIV;
  localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE - 1);
  localparam logic [CNTW-1:0] DIV_LOAD    = CNTW'(CLK_DIV - 1);
  localparam logic [RW-1:0]   LAST_ROW    = RW'(N_ROWS - 1);
  localparam logic [CW-1:0]   LAST_COL    = CW'(N_COLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ROW_SETTLE,
    CLK_HIGH,
    CLK_LOW,
    SAMPLE,
    DONE
  } state_t;

  state_t          state;
  logic            start_q;
  logic [CNTW-1:0] cnt;
  logic            start_rise;

  assign start_rise = bus.start & ~start_q;

  // Every output is a flop loaded together with the state it belongs to,
  // so chip_clk and sample never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.row_en   <= 1'b0;
      bus.row_idx  <= '0;
      bus.col_idx  <= '0;
      bus.chip_clk <= 1'b0;
      bus.sample   <= 1'b0;
    end else begin
      start_q <= bus.start;
      if (state != IDLE && bus.abort) begin
        state        <= IDLE;
        cnt          <= '0;
        bus.busy     <= 1'b0;
        bus.done     <= 1'b0;
        bus.row_en   <= 1'b0;
        bus.row_idx  <= '0;
        bus.col_idx  <= '0;
        bus.chip_clk <= 1'b0;
        bus.sample   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_rise) begin
              state       <= ROW_SETTLE;
              cnt         <= SETTLE_LOAD;
              bus.row_idx <= '0;
              bus.col_idx <= '0;
              bus.row_en  <= 1'b1;
              bus.busy    <= 1'b1;
            end
          end
          ROW_SETTLE: begin
            if (cnt == '0) begin
              state        <= CLK_HIGH;
              cnt          <= DIV_LOAD;
              bus.chip_clk <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          CLK_HIGH: begin
            if (cnt == '0) begin
              state        <= CLK_LOW;
              cnt          <= DIV_LOAD;
              bus.chip_clk <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          CLK_LOW: begin
            if (cnt == '0) begin
              state      <= SAMPLE;
              bus.sample <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SAMPLE: begin
            // Indices stay frozen until the ADC path accepts the sample.
            if (bus.sample_ready) begin
              bus.sample <= 1'b0;
              if (bus.col_idx < LAST_COL) begin
                state        <= CLK_HIGH;
                cnt          <= DIV_LOAD;
                bus.col_idx  <= bus.col_idx + 1'b1;
                bus.chip_clk <= 1'b1;
              end else if (bus.row_idx < LAST_ROW) begin
                state       <= ROW_SETTLE;
                cnt         <= SETTLE_LOAD;
                bus.row_idx <= bus.row_idx + 1'b1;
                bus.col_idx <= '0;
              end else begin
                state      <= DONE;
                bus.done   <= 1'b1;
                bus.row_en <= 1'b0;
              end
            end
          end
          DONE: begin
            state       <= IDLE;
            bus.done    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.row_idx <= '0;
            bus.col_idx <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Self-checking bench: a frame-trace model checks every cycle of a 2x3 sequencer,
// literal frame lengths/orders pin that model, and a 1x1 instance covers the minimal frame.
module tb_pixel_scan_sequencer;

  localparam int NR = 2;
  localparam int NC = 3;
  localparam int CD = 2;
  localparam int ST = 3;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pixel_scan_sequencer_if #(.N_ROWS(NR), .N_COLS(NC)) bus0 ();
  pixel_scan_sequencer_if #(.N_ROWS(1),  .N_COLS(1))  bus1 ();

  pixel_scan_sequencer #(.N_ROWS(NR), .N_COLS(NC), .CLK_DIV(CD), .SETTLE(ST)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  pixel_scan_sequencer #(.N_ROWS(1), .N_COLS(1), .CLK_DIV(1), .SETTLE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    @(posedge clk);
    #1;
    bus0.start = s;
    bus0.abort = a;
  endtask

  // Model: a started frame is expanded into the list of per-cycle outputs it must show.
  typedef struct {
    logic row_en;
    logic chip_clk;
    logic smp;
    logic dn;
    int   row;
    int   col;
  } ent_t;

  ent_t trace[$];
  logic model_start_q;
  logic model_rise;

  function automatic ent_t mk(input logic re, input logic ck, input logic sm, input logic dn, input int r, input int c);
    ent_t e;
    e.row_en = re; e.chip_clk = ck; e.smp = sm; e.dn = dn; e.row = r; e.col = c;
    return e;
  endfunction

  task automatic buildFrame();
    for (int r = 0; r < NR; r++) begin
      repeat (ST) trace.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, r, 0));
      for (int c = 0; c < NC; c++) begin
        repeat (CD) trace.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, r, c));
        repeat (CD) trace.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, r, c));
        trace.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, r, c));
      end
    end
    trace.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, NR - 1, NC - 1));
  endtask

  function automatic logic [7:0] expectedNow();
    if (trace.size() == 0) return 8'h00;
    return {1'b1, trace[0].dn, trace[0].row_en, trace[0].chip_clk, trace[0].smp,
            1'(trace[0].row), 2'(trace[0].col)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      trace.delete();
      model_start_q = 1'b0;
    end else begin
      model_rise    = bus0.start & ~model_start_q;
      model_start_q = bus0.start;
      if (trace.size() != 0) begin
        if (bus0.abort) trace.delete();
        else if (!(trace[0].smp && !bus0.sample_ready)) void'(trace.pop_front());
      end else if (model_rise) begin
        buildFrame();
      end
    end
  end

  logic [7:0] vec0;
  logic [4:0] vec1;
  assign vec0 = {bus0.busy, bus0.done, bus0.row_en, bus0.chip_clk, bus0.sample, bus0.row_idx, bus0.col_idx};
  assign vec1 = {bus1.busy, bus1.done, bus1.row_en, bus1.chip_clk, bus1.sample};

  always @(negedge clk) begin
    if (!rst) checkOutput("cycle_outputs", 32'(vec0), 32'(expectedNow()));
  end

  // ADC ready: stalls the (0,1) sample for stall_left cycles when armed.
  int stall_left = 0;
  always @(negedge clk) begin
    if (stall_left > 0 && bus0.sample && bus0.row_idx == 1'b0 && bus0.col_idx == 2'd1) begin
      bus0.sample_ready = 1'b0;
      stall_left--;
    end else begin
      bus0.sample_ready = 1'b1;
    end
  end

  int xfers[$];
  int done_total = 0;
  always @(posedge clk) begin
    if (!rst && bus0.sample && bus0.sample_ready) xfers.push_back(int'(bus0.row_idx) * NC + int'(bus0.col_idx));
  end
  always @(negedge clk) begin
    if (!rst && bus0.done) done_total++;
  end

  task automatic runFrame(input int sel, output int busy_len, output int done_at, output int pulses,
                          output int max_high, output int min_high, output int done_count);
    logic b, d, c, prev_c;
    int hi;
    busy_len = 0; done_at = -1; pulses = 0; max_high = 0; min_high = 1000; done_count = 0;
    hi = 0; prev_c = 1'b0; b = 1'b0;
    for (int i = 0; i < 5 && !b; i++) begin
      @(negedge clk);
      b = (sel != 0) ? bus1.busy : bus0.busy;
    end
    if (!b) begin
      checkOutput("frame_start_timeout", 0, 1);
      return;
    end
    while (b && busy_len < 500) begin
      busy_len++;
      d = (sel != 0) ? bus1.done : bus0.done;
      c = (sel != 0) ? bus1.chip_clk : bus0.chip_clk;
      if (d) begin
        done_count++;
        done_at = busy_len;
      end
      if (c) hi++;
      else if (prev_c) begin
        pulses++;
        if (hi > max_high) max_high = hi;
        if (hi < min_high) min_high = hi;
        hi = 0;
      end
      prev_c = c;
      @(negedge clk);
      b = (sel != 0) ? bus1.busy : bus0.busy;
    end
    if (b) checkOutput("frame_end_timeout", 0, 1);
  endtask

  task automatic countIdle(input string name, input int cycles);
    int act;
    act = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus0.busy | bus0.row_en | bus0.chip_clk | bus0.sample | bus0.done) act++;
    end
    checkOutput(name, act, 0);
  endtask

  logic [4:0] deg_exp [5] = '{5'b10100, 5'b10110, 5'b10100, 5'b10101, 5'b11000};

  initial begin
    int blen, dat, pul, mxh, mnh, dcnt, done_before;
    logic found;

    rst = 1'b1;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.sample_ready = 1'b1;
    #1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'(vec0), 0);
    #1 rst = 1'b0;
    countIdle("idle_activity", 20);

    // Nominal frame, then start held high: no retrigger.
    xfers.delete();
    applyStimulus(1'b1, 1'b0);
    runFrame(0, blen, dat, pul, mxh, mnh, dcnt);
    checkOutput("nominal_busy_len", blen, 37);
    checkOutput("nominal_done_at", dat, 37);
    checkOutput("nominal_done_count", dcnt, 1);
    checkOutput("nominal_pulses", pul, 6);
    checkOutput("nominal_high_max", mxh, 2);
    checkOutput("nominal_high_min", mnh, 2);
    checkOutput("nominal_xfer_count", xfers.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput("nominal_xfer_order", (i < xfers.size()) ? xfers[i] : -1, i);
    countIdle("start_held_no_retrigger", 10);

    // Backpressure at (0,1) for 5 cycles.
    applyStimulus(1'b0, 1'b0);
    stall_left = 5;
    xfers.delete();
    applyStimulus(1'b1, 1'b0);
    runFrame(0, blen, dat, pul, mxh, mnh, dcnt);
    checkOutput("stall_busy_len", blen, 42);
    checkOutput("stall_pulses", pul, 6);
    checkOutput("stall_xfer_count", xfers.size(), 6);
    checkOutput("stall_consumed", stall_left, 0);

    // Second rise during a frame is ignored and not queued.
    applyStimulus(1'b0, 1'b0);
    fork
      runFrame(0, blen, dat, pul, mxh, mnh, dcnt);
      begin
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
      end
    join
    checkOutput("busy_rise_busy_len", blen, 37);
    countIdle("busy_rise_not_queued", 5);

    // Fresh rise after done, with abort in the same idle cycle.
    fork
      runFrame(0, blen, dat, pul, mxh, mnh, dcnt);
      begin
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
      end
    join
    checkOutput("restart_busy_len", blen, 37);
    checkOutput("restart_done_count", dcnt, 1);

    // Abort in the 2nd CLK_HIGH cycle of (1,0).
    applyStimulus(1'b0, 1'b0);
    xfers.delete();
    done_before = done_total;
    applyStimulus(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus0.chip_clk && bus0.row_idx == 1'b1 && bus0.col_idx == 2'd0) found = 1'b1;
    end
    checkOutput("abort_point_found", 32'(found), 1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("abort_outputs", 32'(vec0), 0);
    countIdle("abort_stays_idle", 10);
    checkOutput("abort_no_done", done_total - done_before, 0);
    checkOutput("abort_xfer_count", xfers.size(), 3);

    // Minimal 1x1 frame on the second instance.
    @(posedge clk);
    #1 bus1.start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("degenerate_seq", 32'(vec1), 32'(deg_exp[i]));
    end
    @(negedge clk);
    checkOutput("degenerate_idle", 32'(vec1), 0);
    bus1.start = 1'b0;

    // Asynchronous reset mid-frame, start held high across it.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    done_before = done_total;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset_outputs", 32'(vec0), 0);
    checkOutput("async_reset_no_done", done_total - done_before, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    runFrame(0, blen, dat, pul, mxh, mnh, dcnt);
    checkOutput("rise_after_reset_busy_len", blen, 37);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
